// File: rtl/toggle_event_receiver.sv
// Toggle-flag event receiver: edge-detects a toggle level and queues events behind valid/ready.
// Build option: define TOGGLE_RX_SYNC_EN to insert a SYNC_STAGES-deep synchronizer on Toggle_In.
module toggle_event_receiver #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Toggle_In,
   input  logic             Event_Ready,
   input  logic             Clear_Ovf,
   output logic             Event_Pulse,
   output logic             Event_Valid,
   output logic [CNT_W-1:0] Pending,
   output logic             Overflow
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("SYNC_STAGES must be in the range 2..4");
   end

   logic             sync_out;
   logic             last_q;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             ovf_q, ovf_d;
   logic             inc, dec;

`ifdef TOGGLE_RX_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Toggle_In};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
`else
   // Toggle_In is assumed synchronous here, so one sampling register suffices.
   logic sample_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sample_q <= 1'b0;
      end else begin
         sample_q <= Toggle_In;
      end
   end

   assign sync_out = sample_q;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         last_q <= 1'b0;
      end else begin
         last_q <= sync_out;
      end
   end

   assign Event_Pulse = sync_out ^ last_q;
   assign Event_Valid = (pending_q != '0);

   assign inc = Event_Pulse;
   assign dec = Event_Valid & Event_Ready;

   // A simultaneous accept frees a slot, so inc+dec never drops even when saturated.
   always_comb begin
      pending_d = pending_q;
      ovf_d     = ovf_q;
      if (Clear_Ovf) begin
         ovf_d = 1'b0;
      end
      unique case ({inc, dec})
         2'b10: begin
            if (pending_q == CntMax) begin
               ovf_d = 1'b1;
            end else begin
               pending_d = pending_q + 1'b1;
            end
         end
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign Pending  = pending_q;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Scoreboard bench for toggle_event_receiver: a wide instance (CNT_W=4) and a saturating
// instance (CNT_W=2) share all inputs; pulses and accepts on the wide one are queue-checked.
module tb_toggle_event_receiver;

   localparam int S = 2;
`ifdef TOGGLE_RX_SYNC_EN
   localparam int P = S - 1;
`else
   localparam int P = 0;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Toggle_In = 1'b1;
   logic       Event_Ready = 1'b0;
   logic       Clear_Ovf = 1'b0;
   logic       pulse_a, valid_a, ovf_a;
   logic [3:0] pend_a;
   logic       pulse_b, valid_b, ovf_b;
   logic [1:0] pend_b;

   toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(4)) dut_a (
      .Clk(Clk), .Reset(Reset), .Toggle_In(Toggle_In), .Event_Ready(Event_Ready),
      .Clear_Ovf(Clear_Ovf), .Event_Pulse(pulse_a), .Event_Valid(valid_a),
      .Pending(pend_a), .Overflow(ovf_a)
   );

   toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(2)) dut_b (
      .Clk(Clk), .Reset(Reset), .Toggle_In(Toggle_In), .Event_Ready(Event_Ready),
      .Clear_Ovf(Clear_Ovf), .Event_Pulse(pulse_b), .Event_Valid(valid_b),
      .Pending(pend_b), .Overflow(ovf_b)
   );

   always #5 Clk = ~Clk;

   int   checks = 0;
   int   fails = 0;
   int   pulse_q[$];
   int   cons_q[$];
   logic prev_pulse = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Monitor: every pulse and every accepted event on dut_a pops one expectation.
   always @(negedge Clk) begin
      if (pulse_a) begin
         chk("pulse_single_cycle", int'(prev_pulse), 0);
         if (pulse_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: got pulse, expected none at %0t", $time);
         end else begin
            chk("pending_at_pulse", int'(pend_a), pulse_q.pop_front());
         end
      end
      if (valid_a && Event_Ready) begin
         if (cons_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_accept: got accept, expected none at %0t", $time);
         end else begin
            chk("pending_at_accept", int'(pend_a), cons_q.pop_front());
         end
      end
      prev_pulse <= pulse_a;
   end

   task automatic flip(input int exp);
      pulse_q.push_back(exp);
      Toggle_In = ~Toggle_In;
      repeat (4) step();
   endtask

   task automatic wait_pulse();
      int n = 0;
      while (!pulse_b && n < 10) begin
         step();
         n++;
      end
      chk("pulse_arrived", int'(pulse_b), 1);
   endtask

   initial begin
      // Reset held with Toggle_In high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_pend_a", int'(pend_a), 0);
         chk("rst_valid_a", int'(valid_a), 0);
         chk("rst_ovf_a", int'(ovf_a), 0);
         chk("rst_pend_b", int'(pend_b), 0);
      end
      Reset = 1'b1;
      pulse_q.push_back(0);
      for (int k = 0; k <= P; k++) begin
         step();
         chk("lat_pulse", int'(pulse_a), (k == P) ? 1 : 0);
         chk("lat_pend0", int'(pend_a), 0);
      end
      step();
      chk("lat_pend1", int'(pend_a), 1);
      chk("lat_valid1", int'(valid_a), 1);
      chk("lat_pulse_off", int'(pulse_a), 0);

      cons_q.push_back(1);
      Event_Ready = 1'b1;
      step();
      Event_Ready = 1'b0;
      chk("drain_pend_a", int'(pend_a), 0);
      chk("drain_valid_a", int'(valid_a), 0);
      chk("drain_pend_b", int'(pend_b), 0);

      // Burst of four
      for (int i = 0; i < 4; i++) flip(i);
      repeat (2) step();
      chk("burst_pend_a", int'(pend_a), 4);
      chk("burst_ovf_a", int'(ovf_a), 0);
      chk("burst_pend_b", int'(pend_b), 3);
      chk("burst_ovf_b", int'(ovf_b), 1);
      for (int i = 0; i < 4; i++) cons_q.push_back(4 - i);
      Event_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("read_pend_a", int'(pend_a), 3 - i);
         chk("read_pend_b", int'(pend_b), (i < 3) ? 2 - i : 0);
      end
      Event_Ready = 1'b0;
      chk("read_valid_a", int'(valid_a), 0);
      chk("read_valid_b", int'(valid_b), 0);
      chk("read_ovf_b", int'(ovf_b), 1);
      Clear_Ovf = 1'b1;
      step();
      Clear_Ovf = 1'b0;
      chk("clr_ovf_b", int'(ovf_b), 0);

      // Re-reset with Toggle_In high: one event counts after release
      Reset = 1'b0;
      #1;
      chk("rr_pend_a", int'(pend_a), 0);
      step();
      Reset = 1'b1;
      pulse_q.push_back(0);
      repeat (4) step();
      for (int i = 1; i <= 5; i++) flip(i);
      repeat (2) step();
      chk("sat_pend_a", int'(pend_a), 6);
      chk("sat_pend_b", int'(pend_b), 3);
      chk("sat_ovf_b", int'(ovf_b), 1);
      Clear_Ovf = 1'b1;
      step();
      Clear_Ovf = 1'b0;
      chk("satclr_ovf_b", int'(ovf_b), 0);
      chk("satclr_pend_b", int'(pend_b), 3);

      // Event and accept in the same cycle while saturated
      pulse_q.push_back(6);
      Toggle_In = ~Toggle_In;
      wait_pulse();
      Event_Ready = 1'b1;
      cons_q.push_back(6);
      step();
      Event_Ready = 1'b0;
      repeat (3) step();
      chk("simul_pend_a", int'(pend_a), 6);
      chk("simul_pend_b", int'(pend_b), 3);
      chk("simul_ovf_b", int'(ovf_b), 0);

      // Clear in the same cycle as a drop: set wins
      pulse_q.push_back(6);
      Toggle_In = ~Toggle_In;
      wait_pulse();
      Clear_Ovf = 1'b1;
      step();
      Clear_Ovf = 1'b0;
      chk("setwins_ovf_b", int'(ovf_b), 1);
      chk("setwins_pend_b", int'(pend_b), 3);
      chk("setwins_pend_a", int'(pend_a), 7);

      // Mid-operation asynchronous reset
      cons_q.push_back(7);
      Event_Ready = 1'b1;
      step();
      Event_Ready = 1'b0;
      chk("pre_pend_a", int'(pend_a), 6);
      chk("pre_pend_b", int'(pend_b), 2);
      chk("pre_ovf_b", int'(ovf_b), 1);
      #3;
      Reset = 1'b0;
      #1;
      chk("async_pend_a", int'(pend_a), 0);
      chk("async_valid_a", int'(valid_a), 0);
      chk("async_pend_b", int'(pend_b), 0);
      chk("async_valid_b", int'(valid_b), 0);
      chk("async_ovf_b", int'(ovf_b), 0);
      step();

      chk("pulse_q_empty", pulse_q.size(), 0);
      chk("cons_q_empty", cons_q.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/toggle_event_receiver.md
# toggle_event_receiver

Receiving end of the toggle-flag event protocol. The transmitter is a toggle flip-flop that inverts its output once per event. This block samples that level, turns each transition into one event, and queues the events in a pending counter. It hands the events one at a time to a consumer over a valid/ready handshake, with saturation and sticky overflow reporting. It sits between any toggle-flag producer (e.g. an interrupt or I/O status flag) and the LC3 control logic that services the events.

## Interface
- SYNC_STAGES, default 2: synchronizer depth on Toggle_In; legal range 2–4; used only when the synchronizer is compiled in.
- CNT_W, default 4: pending-counter width; maximum queued events is 2^CNT_W − 1.
- Clk  input  1  clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- Toggle_In  input  1  toggle level from the transmitter; every transition (0→1 or 1→0) is one event.
- Event_Ready  input  1  consumer accepts one event when high together with Event_Valid.
- Clear_Ovf  input  1  synchronous clear of Overflow.
- Event_Pulse  output  1  high for exactly one cycle per detected transition.
- Event_Valid  output  1  at least one event is pending.
- Pending  output  CNT_W  number of queued, unconsumed events.
- Overflow  output  1  sticky; an event was dropped because the counter was saturated.

## Operation
- Reset low sets all of the following to 0: synchronizer flops, last-level register, Pending counter, Overflow. All outputs therefore read 0 during reset.
- After reset release, Toggle_In = 1 counts as one event. The transmitter also resets to 0, so the two ends start in agreement.
- Edge detect: Event_Pulse = sync_out XOR last_q, where last_q is loaded with sync_out every cycle. The pulse is combinational from flops and lasts exactly one cycle.
- Counter update per cycle, with inc = Event_Pulse and dec = Event_Valid & Event_Ready:
  - inc only, Pending < max: Pending + 1.
  - inc only, Pending = max: Pending is held, the event is dropped, Overflow is set to 1.
  - dec only: Pending − 1.
  - inc and dec together: Pending is unchanged. This holds even at max, and no overflow is raised.
  - neither: Pending holds.
- Event_Valid = (Pending != 0). The output is registered-derived with no combinational path from Event_Ready.
- Event_Ready while Event_Valid = 0 is ignored; Pending never underflows.
- Overflow stays set until a cycle with Clear_Ovf = 1.
  - Clear_Ovf in the same cycle as a new drop: set wins, Overflow stays 1.
  - Clear_Ovf does not change Pending.
- Reset asserted mid-operation discards all queued events and the overflow flag asynchronously.

## Timing
- Toggle_In must be stable around the sampling edge when the synchronizer is compiled out. With the synchronizer in, Toggle_In may be asynchronous.
- Latency with the synchronizer, with the transition sampled at edge 0:
  - sync_out changes after edge SYNC_STAGES−1.
  - Event_Pulse is high in the cycle following that edge.
  - Pending increments at edge SYNC_STAGES; Event_Valid rises then.
  - Total: SYNC_STAGES+1 edges from first sample to Event_Valid.
- Throughput: one event detected per cycle and one event consumed per cycle.
- Toggle_In transitions closer together than one cycle after synchronization may merge. The transmitter must hold each level for at least SYNC_STAGES+1 cycles.

## Configuration
- TOGGLE_RX_SYNC_EN defined: a SYNC_STAGES-deep flop chain feeds the edge detector. Toggle_In is treated as asynchronous.
- TOGGLE_RX_SYNC_EN undefined: a single register samples Toggle_In and SYNC_STAGES is ignored. Event_Pulse is high in the cycle after edge 0, and Event_Valid rises at edge 1.

## Test plan
- Reset: hold Reset = 0 with Toggle_In = 1. Required: Pending = 0, Event_Valid = 0, Overflow = 0 throughout. Release Reset, keep Event_Ready = 0, SYNC_STAGES = 2. Required: Event_Pulse high for one cycle, then Pending = 1 at the 3rd edge.
- Burst: four transitions spaced 4 cycles apart, Event_Ready = 0. Required: Pending = 4 and four single-cycle Event_Pulse. Then Event_Ready = 1. Required: Pending counts 3, 2, 1, 0 on consecutive edges and Event_Valid falls with Pending = 0.
- Saturation (CNT_W = 2): five transitions, no reads. Required: Pending = 3, Overflow = 1. Then a Clear_Ovf pulse. Required: Overflow = 0, Pending = 3.
- Simultaneous: at Pending = 3 (max), a transition arrives while Event_Ready = 1. Required: Pending stays 3 and Overflow stays 0. Also drive Clear_Ovf in the same cycle as a drop. Required: Overflow = 1.
- Mid-operation reset: Pending = 2 with Overflow = 1, then assert Reset between clock edges. Required: Pending, Event_Valid and Overflow go to 0 immediately, with no clock edge needed.
- Build with TOGGLE_RX_SYNC_EN undefined and one transition. Required: Event_Pulse high in the cycle after edge 0 and Pending = 1 after edge 1.
